// File: rtl/shift_add_mul_pkg.sv
// Shared types and select encodings for the shift-add multiplier controller.
package shift_add_mul_pkg;

  localparam int unsigned WIDTH_DEFAULT = 32;
  localparam int unsigned CNT_W_DEFAULT = 6;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StLoad = 2'b01,
    StRun  = 2'b10,
    StDone = 2'b11
  } state_e;

  localparam logic SEL_LOAD  = 1'b1;
  localparam logic SEL_SHIFT = 1'b0;
  localparam logic ADD_ACC   = 1'b0;
  localparam logic ADD_HOLD  = 1'b1;
  localparam logic PROD_CLR  = 1'b1;
  localparam logic PROD_SUM  = 1'b0;

endpackage

// File: rtl/mul_iter_counter.sv
// Iteration counter: synchronous clear, increment, and wrap at terminal count WIDTH-1.
module mul_iter_counter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  localparam logic [CNT_W-1:0] Last = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tc  = (cnt_q == Last);
  assign cnt = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = tc ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/shift_add_mul_ctrl.sv
// Sequencing FSM for the shift-add multiplier datapath (IDLE/LOAD/RUN/DONE).
// Optional early termination on an all-zero B register: SHIFT_ADD_MUL_EARLY_TERM_EN.
module shift_add_mul_ctrl
  import shift_add_mul_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT,
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             iStart,
  input  logic             iB_LSB,
`ifdef SHIFT_ADD_MUL_EARLY_TERM_EN
  input  logic             iB_Zero,
`endif
  output logic             oB_Sel,
  output logic             oA_Sel,
  output logic             oAdd_Sel,
  output logic             oProd_Sel,
  output logic             oShift_Enable,
  output logic             oBusy,
  output logic             oDone,
  output logic [CNT_W-1:0] oIter
);

  state_e           state_q, state_d;
  logic             running;
  logic             early_exit;
  logic             tc;
  logic [CNT_W-1:0] cnt;

  assign running = (state_q == StRun);

`ifdef SHIFT_ADD_MUL_EARLY_TERM_EN
  assign early_exit = running & iB_Zero;
`else
  assign early_exit = 1'b0;
`endif

  // Clearing outside RUN keeps oIter at zero and discards a partial count on early exit.
  mul_iter_counter #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_iter_counter (
    .clk  (Clock),
    .rst_n(Reset_n),
    .clr  (~running | early_exit),
    .inc  (running),
    .cnt  (cnt),
    .tc   (tc)
  );

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (iStart) state_d = StLoad;
      StLoad: state_d = StRun;
      StRun:  if (tc || early_exit) state_d = StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    oB_Sel        = SEL_SHIFT;
    oA_Sel        = SEL_SHIFT;
    oAdd_Sel      = ADD_HOLD;
    oProd_Sel     = PROD_SUM;
    oShift_Enable = 1'b0;
    oBusy         = 1'b0;
    oDone         = 1'b0;
    oIter         = cnt;
    unique case (state_q)
      StIdle: ;
      StLoad: begin
        oB_Sel    = SEL_LOAD;
        oA_Sel    = SEL_LOAD;
        oProd_Sel = PROD_CLR;
        oBusy     = 1'b1;
      end
      StRun: begin
        oShift_Enable = 1'b1;
        oBusy         = 1'b1;
        // Mealy path: accumulate only when the current B bit is set.
        oAdd_Sel      = (iB_LSB && !early_exit) ? ADD_ACC : ADD_HOLD;
      end
      StDone: oDone = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_shift_add_mul_ctrl.sv
// Directed bench: controller driving a behavioural shift-add datapath.
module tb_shift_add_mul_ctrl;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CNT_W = 6;

  logic             Clock = 1'b0;
  logic             Reset_n;
  logic             iStart;
  logic             iB_LSB;
  logic             iB_Zero;
  logic             oB_Sel, oA_Sel, oAdd_Sel, oProd_Sel, oShift_Enable, oBusy, oDone;
  logic [CNT_W-1:0] oIter;

  logic [31:0] data_a, data_b;
  logic [63:0] a_reg, prod_reg;
  logic [31:0] b_reg;

  int total = 0;
  int bad   = 0;

  int          n, busy, acc0, maxit;
  logic [3:0]  seq;
  int          t, d1, d2, loads, dones, found;

  always #5 Clock = ~Clock;

  shift_add_mul_ctrl #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) dut (
    .Clock        (Clock),
    .Reset_n      (Reset_n),
    .iStart       (iStart),
    .iB_LSB       (iB_LSB),
`ifdef SHIFT_ADD_MUL_EARLY_TERM_EN
    .iB_Zero      (iB_Zero),
`endif
    .oB_Sel       (oB_Sel),
    .oA_Sel       (oA_Sel),
    .oAdd_Sel     (oAdd_Sel),
    .oProd_Sel    (oProd_Sel),
    .oShift_Enable(oShift_Enable),
    .oBusy        (oBusy),
    .oDone        (oDone),
    .oIter        (oIter)
  );

  // Datapath model steered only by the controller outputs.
  assign iB_LSB  = b_reg[0];
  assign iB_Zero = (b_reg == 32'd0);

  always @(posedge Clock) begin
    a_reg    <= oA_Sel ? {32'd0, data_a} : (oShift_Enable ? a_reg << 1 : a_reg);
    b_reg    <= oB_Sel ? data_b : (oShift_Enable ? b_reg >> 1 : b_reg);
    prod_reg <= oProd_Sel ? 64'd0 : (oAdd_Sel ? prod_reg : prod_reg + a_reg);
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Number of RUN cycles for a given B operand.
  function automatic int exp_run(input logic [31:0] b);
`ifdef SHIFT_ADD_MUL_EARLY_TERM_EN
    int k;
    k = 0;
    while (b != 32'd0) begin
      b = b >> 1;
      k++;
    end
    return (k == 32) ? 32 : k + 1;
`else
    return 32;
`endif
  endfunction

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, output int cyc,
                        output int nbusy, output int nacc, output logic [3:0] sq,
                        output int mx);
    int r;
    r     = 0;
    cyc   = 0;
    nbusy = 0;
    nacc  = 0;
    sq    = 4'd0;
    mx    = 0;
    data_a = a;
    data_b = b;
    @(negedge Clock);
    iStart = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge Clock);
      iStart = 1'b0;
      cyc++;
      if (oBusy) nbusy++;
      if (oShift_Enable) begin
        if (!oAdd_Sel) nacc++;
        if (r < 4) sq[r] = oAdd_Sel;
        r++;
        if (int'(oIter) > mx) mx = int'(oIter);
      end
      if (oDone) break;
    end
  endtask

  initial begin
    Reset_n = 1'b0;
    iStart  = 1'b0;
    data_a  = 32'd0;
    data_b  = 32'd0;
    #12;
    check_eq("rst_busy", oBusy, 1'b0);
    check_eq("rst_done", oDone, 1'b0);
    check_eq("rst_add_sel", oAdd_Sel, 1'b1);
    check_eq("rst_sels", {oB_Sel, oA_Sel, oProd_Sel, oShift_Enable}, 4'b0000);
    check_eq("rst_iter", oIter, 0);
    @(negedge Clock);
    Reset_n = 1'b1;
    @(negedge Clock);
    check_eq("idle_busy", oBusy, 1'b0);

    // 3 x 5
    run_op(32'd3, 32'd5, n, busy, acc0, seq, maxit);
    check_eq("t1_latency", n, exp_run(32'd5) + 2);
    check_eq("t1_busy_cycles", busy, exp_run(32'd5) + 1);
    check_eq("t1_prod", prod_reg, 64'd15);
    check_eq("t1_iter_in_done", oIter, 0);
    @(negedge Clock);
    check_eq("t1_done_pulse", oDone, 1'b0);

    // all ones squared
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, n, busy, acc0, seq, maxit);
    check_eq("t2_latency", n, 34);
    check_eq("t2_prod", prod_reg, 64'hFFFF_FFFE_0000_0001);
    check_eq("t2_acc_cycles", acc0, 32);
    check_eq("t2_max_iter", maxit, 31);

    // B = 0xA: add-select pattern 1,0,1,0 then holds
    run_op(32'h1234, 32'hA, n, busy, acc0, seq, maxit);
    check_eq("t3_seq", seq, 4'b0101);
    check_eq("t3_acc_cycles", acc0, 2);
    check_eq("t3_prod", prod_reg, 64'hB608);
    check_eq("t3_latency", n, exp_run(32'hA) + 2);

    // iStart held high: restart period and single LOAD per operation
    data_a = 32'd1;
    data_b = 32'hFFFF_FFFF;
    @(negedge Clock);
    iStart = 1'b1;
    t = 0; d1 = -1; d2 = -1; loads = 0;
    for (int i = 0; i < 120; i++) begin
      @(negedge Clock);
      t++;
      if (oProd_Sel && d1 >= 0) loads++;
      if (oDone) begin
        if (d1 < 0) d1 = t;
        else begin
          d2 = t;
          break;
        end
      end
    end
    iStart = 1'b0;
    check_eq("t4_period", d2 - d1, 35);
    check_eq("t4_loads", loads, 1);
    @(negedge Clock);
    @(negedge Clock);
    check_eq("t4_idle_after", oBusy, 1'b0);

    // Asynchronous reset at RUN iteration 10
    data_a = 32'd9;
    data_b = 32'h8000_0000;
    @(negedge Clock);
    iStart = 1'b1;
    found = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge Clock);
      iStart = 1'b0;
      if (oShift_Enable && oIter == 10) begin
        found = 1;
        break;
      end
    end
    check_eq("t5_reached_iter10", found, 1);
    #2 Reset_n = 1'b0;
    #1;
    check_eq("t5_rst_busy", oBusy, 1'b0);
    check_eq("t5_rst_shift", oShift_Enable, 1'b0);
    check_eq("t5_rst_add_sel", oAdd_Sel, 1'b1);
    check_eq("t5_rst_iter", oIter, 0);
    @(negedge Clock);
    Reset_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clock);
      if (oDone) dones++;
    end
    check_eq("t5_no_done", dones, 0);
    run_op(32'd6, 32'd7, n, busy, acc0, seq, maxit);
    check_eq("t5_prod_after", prod_reg, 64'd42);
    check_eq("t5_latency_after", n, exp_run(32'd7) + 2);

`ifdef SHIFT_ADD_MUL_EARLY_TERM_EN
    run_op(32'd7, 32'd2, n, busy, acc0, seq, maxit);
    check_eq("t6_latency_b2", n, 5);
    check_eq("t6_prod_b2", prod_reg, 64'd14);
    run_op(32'd7, 32'd0, n, busy, acc0, seq, maxit);
    check_eq("t6_latency_b0", n, 3);
    check_eq("t6_prod_b0", prod_reg, 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
